// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types and constants for the instruction fetch stage
package if_stage_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DROP  = 3'd3,
        HALT  = 3'd4
    } if_state_t;

    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] RESET_PC   = 16'h0000;

    // True when the instruction word carries the halt opcode
    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:12] == HLT_OPCODE;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - 16-bit program counter register with load enable
module if_pc_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] pc
);

    // PC updates only when the fetch control asks for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with stall, redirect, and halt handling
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] IF_ID_PCplus2,
    output logic [15:0] IF_ID_instruction,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        halted
);

    if_state_t   state, next_state;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] hold_q;
    logic        deliver;
    logic        capture;
    logic        pc_load;
    logic [15:0] pc_load_val;

    if_pc_reg u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    assign pc_plus2          = pc + 16'd2;
    assign imem_addr         = pc;
    assign IF_ID_PCplus2     = pc_plus2;
    // A word parked during a stall is replayed from the hold register
    assign IF_ID_instruction = (state == HOLD) ? hold_q : imem_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Hold register captures a response that arrives while decode is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 16'h0000;
        end else if (capture) begin
            hold_q <= imem_rdata;
        end
    end

    // Next-state and delivery decision; redirect overrides everything
    always_comb begin
        next_state = state;
        deliver    = 1'b0;
        capture    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_valid) begin
                    deliver = ~stall;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    if (!stall) begin
                        deliver    = 1'b1;
                        next_state = FETCH;
                    end else begin
                        capture    = 1'b1;
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    deliver    = 1'b1;
                    next_state = FETCH;
                end
            end
            DROP: begin
                if (imem_valid) begin
                    next_state = FETCH;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        if (deliver && is_halt(IF_ID_instruction)) begin
            next_state = HALT;
        end
        if (redirect) begin
            deliver    = 1'b0;
            capture    = 1'b0;
            // A read still in flight from WAIT must be drained before refetching
            next_state = (state == WAIT && !imem_valid) ? DROP : FETCH;
        end
    end

    // Output decode; reset forces a bubble and no memory traffic
    always_comb begin
        imem_req    = rst_n && (state == FETCH || state == WAIT || state == DROP);
        ifid_wen    = rst_n && deliver;
        ifid_flush  = !rst_n || redirect || (!deliver && !stall);
        halted      = (state == HALT);
        pc_load     = redirect || (deliver && !is_halt(IF_ID_instruction));
        pc_load_val = redirect ? {redirect_pc[15:1], 1'b0} : pc_plus2;
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - table-driven self-checking bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] IF_ID_PCplus2;
    logic [15:0] IF_ID_instruction;
    logic        ifid_wen;
    logic        ifid_flush;
    logic        halted;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .imem_valid        (imem_valid),
        .IF_ID_PCplus2     (IF_ID_PCplus2),
        .IF_ID_instruction (IF_ID_instruction),
        .ifid_wen          (ifid_wen),
        .ifid_flush        (ifid_flush),
        .halted            (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        valid;
        logic [15:0] rdata;
        logic [15:0] e_addr;
        logic        e_req;
        logic        e_wen;
        logic        e_flush;
        logic [15:0] e_instr;
        logic [15:0] e_pcp2;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic rd, input logic [15:0] rpc,
                                input logic vl, input logic [15:0] rdata,
                                input logic [15:0] e_addr, input logic e_req,
                                input logic e_wen, input logic e_flush,
                                input logic [15:0] e_instr, input logic [15:0] e_pcp2,
                                input logic e_halted);
        vec_t v;
        v.stall = st; v.redirect = rd; v.rpc = rpc; v.valid = vl; v.rdata = rdata;
        v.e_addr = e_addr; v.e_req = e_req; v.e_wen = e_wen; v.e_flush = e_flush;
        v.e_instr = e_instr; v.e_pcp2 = e_pcp2; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [15:0] e_addr, input logic e_req,
                               input logic e_wen, input logic e_flush, input logic [15:0] e_instr,
                               input logic [15:0] e_pcp2, input logic e_halted);
        chk({tag, ".addr"},   imem_addr,                 e_addr);
        chk({tag, ".req"},    {15'd0, imem_req},         {15'd0, e_req});
        chk({tag, ".wen"},    {15'd0, ifid_wen},         {15'd0, e_wen});
        chk({tag, ".flush"},  {15'd0, ifid_flush},       {15'd0, e_flush});
        chk({tag, ".pcp2"},   IF_ID_PCplus2,             e_pcp2);
        chk({tag, ".halted"}, {15'd0, halted},           {15'd0, e_halted});
        chk({tag, ".excl"},   {15'd0, ifid_wen & ifid_flush}, 16'd0);
        if (e_wen) chk({tag, ".instr"}, IF_ID_instruction, e_instr);
    endtask

    initial begin
        //            st rd rpc       vl rdata     addr     req wen fl instr     pcp2     hlt
        // sequential fetch from reset, valid tied high
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 1, 1, 0, 16'h1000, 16'h0002, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1001, 16'h0002, 1, 1, 0, 16'h1001, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1002, 16'h0004, 1, 1, 0, 16'h1002, 16'h0006, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1003, 16'h0006, 1, 1, 0, 16'h1003, 16'h0008, 0));
        // redirect to 0x0010, then three slow cycles and a response
        vecs.push_back(mk(0, 1, 16'h0010, 1, 16'h1111, 16'h0008, 1, 0, 1, 16'h0000, 16'h000A, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 0, 1, 16'h0000, 16'h0012, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 0, 1, 16'h0000, 16'h0012, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0010, 1, 0, 1, 16'h0000, 16'h0012, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h1234, 16'h0010, 1, 1, 0, 16'h1234, 16'h0012, 0));
        // WAIT then response under stall: park in HOLD, deliver once on release
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0012, 1, 0, 1, 16'h0000, 16'h0014, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h5678, 16'h0012, 1, 0, 0, 16'h0000, 16'h0014, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0012, 0, 0, 0, 16'h0000, 16'h0014, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'hDEAD, 16'h0012, 0, 1, 0, 16'h5678, 16'h0014, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h9999, 16'h0014, 1, 0, 0, 16'h0000, 16'h0016, 0));
        // redirect to odd 0x0041 while waiting; stale word is dropped
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0014, 1, 0, 1, 16'h0000, 16'h0016, 0));
        vecs.push_back(mk(0, 1, 16'h0041, 0, 16'h0000, 16'h0014, 1, 0, 1, 16'h0000, 16'h0016, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hBAD0, 16'h0040, 1, 0, 1, 16'h0000, 16'h0042, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h2222, 16'h0040, 1, 1, 0, 16'h2222, 16'h0042, 0));
        // redirect to 0x0020, fetch HLT, sit halted, redirect out to 0x0100
        vecs.push_back(mk(0, 1, 16'h0020, 0, 16'h0000, 16'h0042, 1, 0, 1, 16'h0000, 16'h0044, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hF000, 16'h0020, 1, 1, 0, 16'hF000, 16'h0022, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h3333, 16'h0020, 0, 0, 1, 16'h0000, 16'h0022, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0020, 0, 0, 0, 16'h0000, 16'h0022, 1));
        vecs.push_back(mk(0, 1, 16'h0100, 0, 16'h0000, 16'h0020, 0, 0, 1, 16'h0000, 16'h0022, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h4444, 16'h0100, 1, 1, 0, 16'h4444, 16'h0102, 0));
        // wrap at top of address space
        vecs.push_back(mk(0, 1, 16'hFFFF, 1, 16'h0000, 16'h0102, 1, 0, 1, 16'h0000, 16'h0104, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h5555, 16'hFFFE, 1, 1, 0, 16'h5555, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h6666, 16'h0000, 1, 1, 0, 16'h6666, 16'h0002, 0));

        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_valid  = 1'b0;
        imem_rdata  = 16'h0000;
        #2;
        chk_outputs("reset", 16'h0000, 0, 0, 1, 16'h0000, 16'h0002, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n       = 1'b1;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            imem_valid  = vecs[i].valid;
            imem_rdata  = vecs[i].rdata;
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_req, vecs[i].e_wen,
                        vecs[i].e_flush, vecs[i].e_instr, vecs[i].e_pcp2, vecs[i].e_halted);
        end

        // asynchronous reset while waiting on memory: no DROP afterwards
        @(negedge clk);
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_valid = 1'b0;
        #1;
        chk_outputs("pre_wait", 16'h0002, 1, 0, 1, 16'h0000, 16'h0004, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("async_rst", 16'h0000, 0, 0, 1, 16'h0000, 16'h0002, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'h7777;
        #1;
        chk_outputs("post_rst0", 16'h0000, 1, 1, 0, 16'h7777, 16'h0002, 0);
        @(negedge clk);
        imem_rdata = 16'h8888;
        #1;
        chk_outputs("post_rst1", 16'h0002, 1, 1, 0, 16'h8888, 16'h0004, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have no parameters; widths fixed at 16 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stall  in  1  hazard-unit hold; IF/ID contents and PC held.
REQ-005 redirect  in  1  taken branch/jump resolved in decode.
REQ-006 redirect_pc  in  16  branch target; bit 0 forced to 0.
REQ-007 imem_req  out  1  instruction-memory read request.
REQ-008 imem_addr  out  16  read address (= PC).
REQ-009 imem_rdata  in  16  read data, valid when imem_valid=1.
REQ-010 imem_valid  in  1  read completes this cycle (multi-cycle latency allowed).
REQ-011 IF_ID_PCplus2  out  16  PC+2 of the delivered instruction.
REQ-012 IF_ID_instruction  out  16  delivered instruction word.
REQ-013 ifid_wen  out  1  IF/ID buffer write enable.
REQ-014 ifid_flush  out  1  IF/ID buffer clear (bubble insertion).
REQ-015 halted  out  1  HLT fetched; fetch stopped.

Function
REQ-016 States SHALL be FETCH, WAIT, HOLD, DROP, HALT.
REQ-017 imem_req=1 in FETCH, WAIT, DROP; 0 in HOLD, HALT; imem_addr=PC always.
REQ-018 FETCH, imem_valid=1, stall=0, redirect=0: deliver imem_rdata (ifid_wen=1), PC<=PC+2, stay FETCH; zero-bubble throughput.
REQ-019 FETCH, imem_valid=0: ifid_wen=0, ifid_flush=~stall, go WAIT.
REQ-020 FETCH, imem_valid=1, stall=1: discard data, PC held, stay FETCH (memory reads idempotent).
REQ-021 WAIT, imem_valid=1, stall=0: deliver as REQ-018, go FETCH.
REQ-022 WAIT, imem_valid=1, stall=1: capture imem_rdata into hold register, go HOLD.
REQ-023 WAIT, imem_valid=0: ifid_wen=0, ifid_flush=~stall.
REQ-024 HOLD: IF_ID_instruction=hold register; stall=0 -> deliver, PC<=PC+2, go FETCH.
REQ-025 redirect=1 SHALL take priority over stall and all states: PC<=redirect_pc&16'hFFFE, ifid_flush=1, ifid_wen=0, delivered data discarded.
REQ-026 Redirect in WAIT with imem_valid=0 SHALL go DROP; otherwise go FETCH.
REQ-027 DROP: ignore data; on imem_valid=1 go FETCH; ifid_flush=~stall each DROP cycle.
REQ-028 Delivered instruction with bits[15:12]=HLT_OPCODE SHALL be delivered normally, PC held, go HALT.
REQ-029 HALT: halted=1, ifid_wen=0, ifid_flush=~stall; only redirect or reset exit (redirect -> FETCH, halted=0 next cycle).
REQ-030 IF_ID_PCplus2=PC+2 mod 2^16; 16'hFFFE wraps to 16'h0000.
REQ-031 ifid_wen and ifid_flush SHALL never both be 1.

Reset
REQ-032 rst_n=0 SHALL asynchronously force PC=RESET_PC (16'h0000), state FETCH, hold register 0, halted=0.
REQ-033 During reset ifid_wen=0, ifid_flush=1, imem_req=0.
REQ-034 Reset mid-WAIT SHALL not enter DROP; any memory response in the first post-reset cycle is treated as the PC=0 read.

Structure
REQ-035 Shared package SHALL hold if_state_t enum, HLT_OPCODE (4'hF), RESET_PC (16'h0000).
REQ-036 PC register SHALL be sub-module if_pc_reg (16-bit, async active-low reset, load enable, load value).
REQ-037 Next-PC selection and FSM in if_stage; no combinational path imem_rdata -> imem_addr.

Verification
REQ-038 Reset, imem_valid tied 1, 4 cycles -> imem_addr 0,2,4,6; IF_ID_PCplus2 2,4,6,8; ifid_wen=1 each cycle.
REQ-039 PC=0x0010, imem_valid low 3 cycles then 0x1234 -> 3 flush cycles, then IF_ID_instruction=0x1234, PCplus2=0x0012.
REQ-040 WAIT, valid with stall=1 for 2 cycles -> HOLD, ifid_wen=0, ifid_flush=0; stall drop -> held word delivered once.
REQ-041 Redirect to 0x0041 during WAIT, stale data returns -> DROP, stale word never delivered, next fetch addr 0x0040.
REQ-042 Fetch 0xF000 at PC=0x0020 -> delivered, halted=1, PC stays 0x0020; redirect to 0x0100 -> resumes at 0x0100.
REQ-043 PC=0xFFFE with valid -> PCplus2=0x0000, next imem_addr=0x0000.
